// File: rtl/axi4_pkg.sv
// Shared AXI4 types and constants for the request arbiter slice.
package axi4_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } axi_burst_t;

  // Captured id/addr are stored at these widths; narrower ports zero-extend.
  localparam int unsigned AxiIdWidthMax   = 16;
  localparam int unsigned AxiAddrWidthMax = 64;
  localparam int unsigned AXI_4KB         = 4096;

  typedef struct packed {
    logic [AxiIdWidthMax-1:0]   id;
    logic [AxiAddrWidthMax-1:0] addr;
    logic [7:0]                 len;
    logic [2:0]                 size;
    axi_burst_t                 burst;
    logic                       wr;
    logic                       err;
  } axi_req_t;

endpackage

// File: rtl/axi4_burst_chk.sv
// Combinational legality check of one AXI4 address-phase payload.
module axi4_burst_chk
  import axi4_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic [11:0] addr_lo_i,
  input  logic [7:0]  len_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  burst_i,
  output logic        err_o
);

  localparam int unsigned MaxSize = $clog2(AXI_DATA_WIDTH / 8);

  // 17 bits holds 4095 + 256 * 128 without wrapping.
  logic [16:0] bytes;
  logic [16:0] end_addr;

  always_comb begin
    bytes    = (17'(len_i) + 17'd1) << size_i;
    end_addr = 17'(addr_lo_i) + bytes;
    err_o    = 1'b0;
    if (burst_i == 2'b11) begin
      err_o = 1'b1;
    end
    if (32'(size_i) > MaxSize) begin
      err_o = 1'b1;
    end
    if (burst_i == BurstWrap && !(len_i inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
      err_o = 1'b1;
    end
    if (burst_i == BurstFixed && len_i > 8'd15) begin
      err_o = 1'b1;
    end
    if (burst_i == BurstIncr && end_addr > 17'(AXI_4KB)) begin
      err_o = 1'b1;
    end
  end

endmodule

// File: rtl/axi4_req_arb.sv
// Round-robin AR/AW arbiter feeding one outstanding request to the SRAM core.
module axi4_req_arb
  import axi4_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      arvalid_i,
  output logic                      arready_o,
  input  logic [AXI_ID_WIDTH-1:0]   arid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] araddr_i,
  input  logic [7:0]                arlen_i,
  input  logic [2:0]                arsize_i,
  input  logic [1:0]                arburst_i,
  input  logic                      awvalid_i,
  output logic                      awready_o,
  input  logic [AXI_ID_WIDTH-1:0]   awid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] awaddr_i,
  input  logic [7:0]                awlen_i,
  input  logic [2:0]                awsize_i,
  input  logic [1:0]                awburst_i,
  output logic                      req_valid_o,
  input  logic                      req_ready_i,
  output logic                      req_wr_o,
  output logic [AXI_ID_WIDTH-1:0]   req_id_o,
  output logic [AXI_ADDR_WIDTH-1:0] req_addr_o,
  output logic [7:0]                req_len_o,
  output logic [2:0]                req_size_o,
  output logic [1:0]                req_burst_o,
  output logic                      req_err_o,
  input  logic                      done_i
);

  typedef enum logic [1:0] {StIdle, StHold, StBusy} state_e;

  state_e   state_q;
  logic     last_wr_q;
  logic     req_valid_q;
  axi_req_t req_q;

  logic                      grant_ar;
  logic                      grant_aw;
  logic [AXI_ID_WIDTH-1:0]   sel_id;
  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]                sel_len;
  logic [2:0]                sel_size;
  logic [1:0]                sel_burst;
  logic                      sel_err;

  // Ready is a same-cycle function of the grant; reset suppresses any handshake.
  always_comb begin
    grant_ar = 1'b0;
    grant_aw = 1'b0;
    if (state_q == StIdle && !rst_i) begin
      if (arvalid_i && awvalid_i) begin
        grant_aw = ~last_wr_q;
        grant_ar = last_wr_q;
      end else begin
        grant_ar = arvalid_i;
        grant_aw = awvalid_i;
      end
    end
  end

  assign arready_o = grant_ar;
  assign awready_o = grant_aw;

  assign sel_id    = grant_aw ? awid_i    : arid_i;
  assign sel_addr  = grant_aw ? awaddr_i  : araddr_i;
  assign sel_len   = grant_aw ? awlen_i   : arlen_i;
  assign sel_size  = grant_aw ? awsize_i  : arsize_i;
  assign sel_burst = grant_aw ? awburst_i : arburst_i;

  axi4_burst_chk #(
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH)
  ) u_burst_chk (
    .addr_lo_i(sel_addr[11:0]),
    .len_i    (sel_len),
    .size_i   (sel_size),
    .burst_i  (sel_burst),
    .err_o    (sel_err)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      last_wr_q   <= 1'b1;
      req_valid_q <= 1'b0;
      req_q       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_ar || grant_aw) begin
            req_q.id    <= AxiIdWidthMax'(sel_id);
            req_q.addr  <= AxiAddrWidthMax'(sel_addr);
            req_q.len   <= sel_len;
            req_q.size  <= sel_size;
            req_q.burst <= axi_burst_t'(sel_burst);
            req_q.wr    <= grant_aw;
            req_q.err   <= sel_err;
            last_wr_q   <= grant_aw;
            req_valid_q <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (req_ready_i) begin
            req_valid_q <= 1'b0;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          if (done_i) begin
            state_q <= StIdle;
          end
        end
        default: begin
          req_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_wr_o    = req_q.wr;
  assign req_id_o    = req_q.id[AXI_ID_WIDTH-1:0];
  assign req_addr_o  = req_q.addr[AXI_ADDR_WIDTH-1:0];
  assign req_len_o   = req_q.len;
  assign req_size_o  = req_q.size;
  assign req_burst_o = req_q.burst;
  assign req_err_o   = req_q.err;

  // Storage beyond the configured widths is always zero.
  logic unused_hi;
  assign unused_hi = ^{req_q.id, req_q.addr};

endmodule

// File: doc/axi4_req_arb.md
AXI4_REQ_ARB -- requirements
Module: axi4_req_arb

Interface
REQ-001 The block SHALL have parameter AXI_ADDR_WIDTH, default 32, giving the address width.
REQ-002 The block SHALL have parameter AXI_DATA_WIDTH, default 64, giving the data bus width; max legal size is log2(AXI_DATA_WIDTH/8).
REQ-003 The block SHALL have parameter AXI_ID_WIDTH, default 4, giving the ID width.
REQ-004 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-005 The ports SHALL be, clock and reset first:
- clk_i  in  1  clock
- rst_i  in  1  sync active-high reset
- arvalid_i/arready_o  in/out  1  AR handshake
- arid_i, araddr_i, arlen_i, arsize_i, arburst_i  in  ID/ADDR/8/3/2  AR payload
- awvalid_i/awready_o  in/out  1  AW handshake
- awid_i, awaddr_i, awlen_i, awsize_i, awburst_i  in  ID/ADDR/8/3/2  AW payload
- req_valid_o/req_ready_i  out/in  1  request to the SRAM core
- req_wr_o  out  1  1=write, 0=read
- req_id_o, req_addr_o, req_len_o, req_size_o, req_burst_o  out  ID/ADDR/8/3/2  granted payload
- req_err_o  out  1  illegal burst; downstream answers SLVERR
- done_i  in  1  pulse: last R beat or B handshake completed

Function
REQ-006 The FSM SHALL have three states: IDLE, HOLD and BUSY. Only one transaction SHALL be outstanding at a time.
REQ-007 In IDLE, when the grant logic selects a valid channel, the block SHALL assert that channel's ready combinationally in the same cycle, capture its payload, and go to HOLD. The other channel's ready SHALL stay 0.
REQ-008 Arbitration SHALL be round-robin. A 1-bit last_wr register records the last grant. If both channels are valid, the block SHALL grant AW if last_wr=0 and AR if last_wr=1. A single valid channel SHALL always win.
REQ-009 In HOLD, req_valid_o SHALL be 1 and the payload SHALL be stable. On req_ready_i the block SHALL go to BUSY.
REQ-010 req_valid_o SHALL rise exactly 1 cycle after the address handshake. There is no combinational path from the arvalid_i or awvalid_i inputs to req_valid_o.
REQ-011 In BUSY, arready_o, awready_o and req_valid_o SHALL be 0. done_i SHALL move the block to IDLE. A new grant is possible no earlier than the cycle after done_i.
REQ-012 done_i SHALL be ignored in IDLE and HOLD.
REQ-013 req_err_o SHALL be computed at capture and registered with the payload. It SHALL be 1 if any of the following holds:
- burst is 2'b11;
- size > log2(AXI_DATA_WIDTH/8);
- burst is WRAP and len is not in {1,3,7,15};
- burst is FIXED and len > 15;
- burst is INCR and addr[11:0] + ((len+1) << size) > 4096, computed in 13+ bit unsigned arithmetic with no truncation.
REQ-014 Errored requests SHALL still be forwarded through HOLD and BUSY like any other request.
REQ-015 last_wr SHALL update only on a grant.

Reset
REQ-016 While rst_i=1 at a clock edge, the block SHALL take these values:
- state = IDLE, last_wr = 1 (AR wins the first tie);
- all captured payload = 0, req_err_o = 0;
- req_valid_o = 0, arready_o = 0, awready_o = 0.
REQ-017 Reset asserted in HOLD or BUSY SHALL abandon the transaction without any further req_valid_o.

Structure
REQ-018 Package axi4_pkg SHALL hold:
- axi_burst_t (FIXED=00, INCR=01, WRAP=10);
- axi_req_t (id, addr, len, size, burst, wr, err);
- localparam AXI_4KB = 4096.
REQ-019 The legality checks SHALL live in one combinational sub-module, axi4_burst_chk, instantiated once on the muxed winning payload.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset then AR only (araddr=0x100, len=3, INCR) -> arready_o=1 in that cycle; req_valid_o=1 next cycle; req_wr_o=0, req_err_o=0.
- AR and AW valid together, repeated 4 transactions with done_i after each -> grant order AR, AW, AR, AW.
- AW with addr=0xFF8, len=1, size=3, INCR -> req_err_o=1, since 0xFF8+16 > 4096; request still forwarded.
- WRAP len=5 -> req_err_o=1. WRAP len=7 at addr=0x38 -> req_err_o=0.
- Hold req_ready_i=0 for 5 cycles in HOLD -> payload stable; arready_o and awready_o stay 0. done_i pulsed in HOLD -> no state change.
- rst_i=1 while in BUSY -> next cycle IDLE, req_valid_o=0. A pending AR is then granted one cycle after rst_i falls.
